// File: rtl/issue_exec_stage_divrem.sv
// Multi-cycle radix-2 restoring divide/remainder unit. It takes one op from the RS,
// iterates one bit per cycle, and holds the tagged result until the writeback grant.
module issue_exec_stage_divrem #(
  parameter int WIDTH      = 64,
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int CMD_W      = 10
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  readyRS_i,
  output logic                  stallRS_o,
  input  logic [WIDTH-1:0]      reservationStationVal1_i,
  input  logic [WIDTH-1:0]      reservationStationVal2_i,
  input  logic [CMD_W-1:0]      reservationStationCommands_i,
  input  logic [ROBsizeLog-1:0] reservationStationTag_i,
  input  logic                  isSigned_i,
  input  logic                  wantRem_i,
  input  logic                  canGo_i,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      executeVal_o,
  output logic [CMD_W-1:0]      executeCommands_o,
  output logic [ROBsizeLog-1:0] executeTag_o,
  output logic [3:0]            executeFlags_o
);
  // state | meaning
  // IDLE  | no op held; ready to accept
  // BUSY  | restoring iterations in progress, cnt counts down to 0
  // DONE  | result held on outputs until canGo_i
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;
  logic accept, fast, div_zero, sgn_ovf;
  logic neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2, fast_val;
  logic [WIDTH-1:0] dvd_q, dvs, rem;
  logic q_neg, r_neg, want_rem;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0] rem_shift, diff;
  logic q_bit;
  logic [WIDTH-1:0] q_next, r_next, q_fix, r_fix, res;

  assign stallRS_o = reset_i | flush_i | ~((state == IDLE) | ((state == DONE) & canGo_i));
  assign accept    = readyRS_i & ~stallRS_o;
  assign valid_o   = (state == DONE);

  assign neg1     = isSigned_i & reservationStationVal1_i[WIDTH-1];
  assign neg2     = isSigned_i & reservationStationVal2_i[WIDTH-1];
  assign mag1     = neg1 ? -reservationStationVal1_i : reservationStationVal1_i;
  assign mag2     = neg2 ? -reservationStationVal2_i : reservationStationVal2_i;
  assign div_zero = (reservationStationVal2_i == '0);
  assign sgn_ovf  = isSigned_i & (reservationStationVal1_i == MIN_V) & (&reservationStationVal2_i);
  assign fast     = div_zero | sgn_ovf;
  assign fast_val = div_zero ? (wantRem_i ? reservationStationVal1_i : '1)
                             : (wantRem_i ? '0 : MIN_V);

  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom
  assign rem_shift = {rem, dvd_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs};
  assign q_bit     = ~diff[WIDTH];
  assign q_next    = {dvd_q[WIDTH-2:0], q_bit};
  assign r_next    = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign q_fix     = q_neg ? -q_next : q_next;
  assign r_fix     = r_neg ? -r_next : r_next;
  assign res       = want_rem ? r_fix : q_fix;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = fast ? DONE : BUSY;
    end else begin
      case (state)
        BUSY:    if (cnt == '0) state_nxt = DONE;
        DONE:    if (canGo_i) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dvd_q             <= '0;
      dvs               <= '0;
      rem               <= '0;
      cnt               <= '0;
      q_neg             <= 1'b0;
      r_neg             <= 1'b0;
      want_rem          <= 1'b0;
      executeVal_o      <= '0;
      executeCommands_o <= '0;
      executeTag_o      <= '0;
      executeFlags_o    <= '0;
    end else if (accept) begin
      dvd_q             <= mag1;
      dvs               <= mag2;
      rem               <= '0;
      cnt               <= CNT_W'(WIDTH - 1);
      q_neg             <= neg1 ^ neg2;
      r_neg             <= neg1;
      want_rem          <= wantRem_i;
      executeCommands_o <= reservationStationCommands_i;
      executeTag_o      <= reservationStationTag_i;
      if (fast) begin
        executeVal_o   <= fast_val;
        executeFlags_o <= {fast_val[WIDTH-1], fast_val == '0, sgn_ovf, div_zero};
      end
    end else if (state == BUSY && !flush_i) begin
      dvd_q <= q_next;
      rem   <= r_next;
      cnt   <= cnt - 1'b1;
      if (cnt == '0) begin
        executeVal_o   <= res;
        executeFlags_o <= {res[WIDTH-1], res == '0, 2'b00};
      end
    end
  end
endmodule

// File: tb/tb_issue_exec_stage_divrem.sv
// Directed bench for issue_exec_stage_divrem: a vector table of single ops plus
// hand sequences for back-to-back issue, flush and asynchronous reset.
module tb_issue_exec_stage_divrem;
  localparam int W = 64;
  localparam int TW = 6;
  localparam int CW = 10;

  logic clk = 0, rst = 1, flush = 0, ready = 0, can_go = 0, sgn = 0, wrem = 0;
  logic stall, valid;
  logic [W-1:0] a = 0, b = 0, val;
  logic [CW-1:0] cmd = 0, cmd_o;
  logic [TW-1:0] tag = 0, tag_o;
  logic [3:0] flags;

  int errors = 0, checks = 0;

  issue_exec_stage_divrem dut (
    .clk_i(clk), .reset_i(rst), .flush_i(flush), .readyRS_i(ready), .stallRS_o(stall),
    .reservationStationVal1_i(a), .reservationStationVal2_i(b),
    .reservationStationCommands_i(cmd), .reservationStationTag_i(tag),
    .isSigned_i(sgn), .wantRem_i(wrem), .canGo_i(can_go), .valid_o(valid),
    .executeVal_o(val), .executeCommands_o(cmd_o), .executeTag_o(tag_o),
    .executeFlags_o(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic         r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [3:0]   fl;
    int           lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drives one op at a negedge and returns just after the accept edge
  task automatic issue(input logic s, input logic r, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [TW-1:0] t, input logic [CW-1:0] c);
    @(negedge clk);
    sgn = s; wrem = r; a = x; b = y; tag = t; cmd = c; ready = 1;
    #1 check("stall_at_issue", W'(stall), 0);
    @(posedge clk); #1 ready = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 200) begin
      @(posedge clk); #1 n++;
    end
  endtask

  task automatic release_result;
    @(negedge clk); can_go = 1;
    @(posedge clk); #1 can_go = 0;
    check("idle_after_grant", W'(valid), 0);
  endtask

  task automatic run_vec(input int i);
    int n;
    issue(vecs[i].s, vecs[i].r, vecs[i].a, vecs[i].b, TW'(i + 1), CW'(i * 3 + 10));
    wait_valid(n);
    check($sformatf("v%0d_latency", i), W'(n), W'(vecs[i].lat));
    check($sformatf("v%0d_val", i), val, vecs[i].q);
    check($sformatf("v%0d_flags", i), W'(flags), W'(vecs[i].fl));
    check($sformatf("v%0d_tag", i), W'(tag_o), W'(i + 1));
    check($sformatf("v%0d_cmd", i), W'(cmd_o), W'(i * 3 + 10));
    release_result();
  endtask

  initial begin
    int n, highs;
    logic [W-1:0] minv;
    minv = {1'b1, {(W-1){1'b0}}};
    vecs[0]  = '{0, 0, 15, 3, 5, 4'b0000, 64};
    vecs[1]  = '{1, 0, -64'd7, 2, -64'd3, 4'b1000, 64};
    vecs[2]  = '{1, 1, -64'd7, 2, -64'd1, 4'b1000, 64};
    vecs[3]  = '{1, 1, 7, -64'd2, 1, 4'b0000, 64};
    vecs[4]  = '{0, 0, 42, 0, '1, 4'b1001, 0};
    vecs[5]  = '{0, 1, 42, 0, 42, 4'b0001, 0};
    vecs[6]  = '{1, 0, minv, '1, minv, 4'b1010, 0};
    vecs[7]  = '{1, 1, minv, '1, 0, 4'b0110, 0};
    vecs[8]  = '{0, 0, minv, '1, 0, 4'b0100, 64};
    vecs[9]  = '{0, 0, 100, 7, 14, 4'b0000, 64};
    vecs[10] = '{1, 0, -64'd9, -64'd4, 2, 4'b0000, 64};
    vecs[11] = '{1, 1, -64'd9, -64'd4, -64'd1, 4'b1000, 64};
    vecs[12] = '{0, 0, '1, 2, {1'b0, {(W-1){1'b1}}}, 4'b0000, 64};
    vecs[13] = '{1, 0, 42, 0, '1, 4'b1001, 0};

    #2;
    check("rst_stall", W'(stall), 1);
    check("rst_valid", W'(valid), 0);
    check("rst_val", val, 0);
    check("rst_tag", W'(tag_o), 0);
    check("rst_cmd", W'(cmd_o), 0);
    check("rst_flags", W'(flags), 0);
    #20 rst = 0;

    // first op held across idle grants
    issue(0, 0, 15, 3, 3, 10);
    wait_valid(n);
    check("hold_latency", W'(n), 64);
    repeat (3) @(posedge clk);
    #1;
    check("hold_valid", W'(valid), 1);
    check("hold_val", val, 5);
    check("hold_tag", W'(tag_o), 3);
    check("hold_cmd", W'(cmd_o), 10);
    check("hold_stall", W'(stall), 1);
    release_result();

    for (int i = 0; i < 14; i++) run_vec(i);

    // back-to-back: grant and new accept in the same cycle
    issue(0, 0, 20, 4, 5, 1);
    wait_valid(n);
    check("b2b_first_val", val, 5);
    @(negedge clk);
    can_go = 1; ready = 1; sgn = 0; wrem = 0; a = 100; b = 7; tag = 6; cmd = 2;
    #1 check("b2b_stall", W'(stall), 0);
    @(posedge clk); #1 can_go = 0; ready = 0;
    check("b2b_valid_drop", W'(valid), 0);
    wait_valid(n);
    check("b2b_latency", W'(n), 64);
    check("b2b_val", val, 14);
    check("b2b_tag", W'(tag_o), 6);
    release_result();

    // flush mid-BUSY: nothing emitted
    issue(0, 0, 1000, 3, 7, 3);
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1;
    #1 check("flush_stall", W'(stall), 1);
    @(posedge clk); #1 flush = 0;
    highs = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1 if (valid) highs++;
    end
    check("flush_busy_no_result", W'(highs), 0);

    // flush in DONE overrides a grant with a pending RS op
    issue(0, 0, 42, 0, 8, 4);
    check("flush_done_valid", W'(valid), 1);
    @(negedge clk); flush = 1; can_go = 1; ready = 1;
    #1 check("flush_done_stall", W'(stall), 1);
    @(posedge clk); #1 flush = 0; can_go = 0; ready = 0;
    check("flush_done_drop", W'(valid), 0);
    repeat (3) @(posedge clk);
    #1 check("flush_done_idle", W'(valid), 0);
    issue(0, 0, 100, 7, 9, 5);
    wait_valid(n);
    check("post_flush_q", val, 14);
    release_result();
    issue(0, 1, 100, 7, 10, 6);
    wait_valid(n);
    check("post_flush_r", val, 2);
    release_result();

    // async reset mid-BUSY between clock edges
    issue(0, 0, 500, 5, 11, 7);
    repeat (10) @(posedge clk);
    #3 rst = 1;
    #1;
    check("arst_tag", W'(tag_o), 0);
    check("arst_cmd", W'(cmd_o), 0);
    check("arst_valid", W'(valid), 0);
    check("arst_stall", W'(stall), 1);
    @(negedge clk); rst = 0;
    highs = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1 if (valid) highs++;
    end
    check("arst_no_result", W'(highs), 0);
    issue(0, 0, 0, 5, 12, 8);
    wait_valid(n);
    check("arst_next_val", val, 0);
    check("arst_next_flags", W'(flags), W'(4'b0100));
    release_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
